// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad entry sequencer for the calculator's add/subtract ALU.
// Collects operand A, operator and operand B from decoded key strobes. On '='
// it presents the operands to the ALU, waits out its latency, and then captures
// the result for the display. SHOW supports chaining and repeating the last
// operation.
module calc_seq_ctrl #(
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] alu_num1,
  output logic [W-1:0] alu_num2,
  output logic         alu_op,
  input  logic [W:0]   alu_result,
  output logic [W:0]   disp_value,
  output logic         result_valid,
  output logic         negative,
  output logic         entry_err,
  output logic         busy
);

  // The counter must be able to reach ALU_LAT.
  localparam int CW = $clog2(ALU_LAT + 2);
  localparam logic [CW-1:0] LAT_C = CW'(ALU_LAT);

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_ENTER_B = 2'd1,
    S_EXEC    = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          op_q, op_d;
  logic          b_ent_q, b_ent_d;
  logic [W:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  num1_q, num1_d;
  logic [W-1:0]  num2_q, num2_d;
  logic          aluop_q, aluop_d;
  logic [W:0]    disp_q, disp_d;
  logic          rv_q, rv_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  // Decimal accumulate: {accepted, value}. On overflow the old value is
  // returned and accepted is 0. The intermediate needs 4 extra bits so that
  // acc*10+9 cannot wrap.
  function automatic logic [W:0] accum(input logic [W-1:0] acc, input logic [3:0] d);
    logic [W+3:0] ext;
    ext = (W+4)'(acc) * (W+4)'(10) + (W+4)'(d);
    if (ext[W+3:W] == '0) accum = {1'b1, ext[W-1:0]};
    else                  accum = {1'b0, acc};
  endfunction

  logic         is_digit, is_op, is_eq, is_clr;
  logic [W:0]   acc_a, acc_b;
  logic         chain_ok;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
  assign is_eq    = key_valid && (key_code == 4'd12);
  assign is_clr   = key_valid && (key_code == 4'd13);
  assign acc_a    = accum(a_q, key_code);
  assign acc_b    = accum(b_q, key_code);
  // A held result may seed a new operation only if it is non-negative and fits W bits.
  assign chain_ok = !neg_q && !r_q[W];

  // Next-state and registered-output logic for the key sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    b_ent_d = b_ent_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    aluop_d = aluop_q;
    disp_d  = disp_q;
    rv_d    = rv_q;
    neg_d   = neg_q;
    err_d   = err_q;

    case (state_q)
      S_ENTER_A: begin
        if (is_digit) begin
          a_d    = acc_a[W-1:0];
          err_d  = err_q | ~acc_a[W];
          disp_d = {1'b0, acc_a[W-1:0]};
        end else if (is_op) begin
          op_d    = key_code[0];
          b_d     = '0;
          b_ent_d = 1'b0;
          state_d = S_ENTER_B;
        end else if (is_clr) begin
          a_d    = '0;
          err_d  = 1'b0;
          disp_d = '0;
        end
      end

      S_ENTER_B: begin
        if (is_digit) begin
          b_d     = acc_b[W-1:0];
          b_ent_d = 1'b1;
          err_d   = err_q | ~acc_b[W];
          disp_d  = {1'b0, acc_b[W-1:0]};
        end else if (is_op) begin
          op_d = key_code[0];
        end else if (is_eq && b_ent_q) begin
          num1_d  = a_q;
          num2_d  = b_q;
          aluop_d = op_q;
          cnt_d   = '0;
          rv_d    = 1'b0;
          neg_d   = 1'b0;
          state_d = S_EXEC;
        end else if (is_clr) begin
          b_d     = '0;
          b_ent_d = 1'b0;
          err_d   = 1'b0;
          disp_d  = '0;
        end
      end

      // Keys are ignored here; ALU inputs stay frozen until the capture.
      S_EXEC: begin
        if (cnt_q == LAT_C) begin
          r_d     = alu_result;
          disp_d  = alu_result;
          neg_d   = op_q & (a_q < b_q);
          rv_d    = 1'b1;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHOW: begin
        if (is_digit) begin
          a_d     = W'(key_code);
          disp_d  = {1'b0, W'(key_code)};
          rv_d    = 1'b0;
          neg_d   = 1'b0;
          state_d = S_ENTER_A;
        end else if (is_op) begin
          if (chain_ok) begin
            a_d     = r_q[W-1:0];
            op_d    = key_code[0];
            b_d     = '0;
            b_ent_d = 1'b0;
            rv_d    = 1'b0;
            state_d = S_ENTER_B;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_eq) begin
          // Repeat the last operation with the result as the new A.
          if (chain_ok) begin
            a_d     = r_q[W-1:0];
            num1_d  = r_q[W-1:0];
            num2_d  = b_q;
            aluop_d = op_q;
            cnt_d   = '0;
            rv_d    = 1'b0;
            neg_d   = 1'b0;
            state_d = S_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_clr) begin
          state_d = S_ENTER_A;
          a_d     = '0;
          b_d     = '0;
          op_d    = 1'b0;
          b_ent_d = 1'b0;
          r_d     = '0;
          cnt_d   = '0;
          num1_d  = '0;
          num2_d  = '0;
          aluop_d = 1'b0;
          disp_d  = '0;
          rv_d    = 1'b0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_ENTER_A;
    endcase

    busy_d = (state_d == S_EXEC);
  end

  // State and output registers; clear aborts everything immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      b_ent_q <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      aluop_q <= 1'b0;
      disp_q  <= '0;
      rv_q    <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      b_ent_q <= b_ent_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      aluop_q <= aluop_d;
      disp_q  <= disp_d;
      rv_q    <= rv_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign alu_num1     = num1_q;
  assign alu_num2     = num2_q;
  assign alu_op       = aluop_q;
  assign disp_value   = disp_q;
  assign result_valid = rv_q;
  assign negative     = neg_q;
  assign entry_err    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: a registered ALU stand-in, a key-level behavioural
// model, a per-cycle compare process and directed key sequences with literal
// expectations.
module tb_calc_seq_ctrl;
  localparam int W       = 4;
  localparam int ALU_LAT = 1;

  logic         clk = 1'b0;
  logic         clear;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] alu_num1, alu_num2;
  logic         alu_op;
  logic [W:0]   alu_result = '0;
  logic [W:0]   disp_value;
  logic         result_valid, negative, entry_err, busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  calc_seq_ctrl #(.W(W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
    .alu_result(alu_result), .disp_value(disp_value),
    .result_valid(result_valid), .negative(negative),
    .entry_err(entry_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in with one registered stage.
  always @(posedge clk)
    alu_result <= alu_op ? ({1'b0, alu_num1} - {1'b0, alu_num2})
                         : ({1'b0, alu_num1} + {1'b0, alu_num2});

  // ---------------- behavioural model ----------------
  localparam int M_A = 0, M_B = 1, M_RUN = 2, M_SHOW = 3;
  int m_mode, m_a, m_b, m_op, m_r, m_left, m_pend, m_pneg;
  bit m_bent;
  int e_n1, e_n2, e_op, e_disp, e_rv, e_neg, e_err, e_busy;

  task automatic m_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_r = 0; m_left = 0;
    m_pend = 0; m_pneg = 0; m_bent = 0;
    e_n1 = 0; e_n2 = 0; e_op = 0; e_disp = 0; e_rv = 0; e_neg = 0;
    e_err = 0; e_busy = 0;
  endtask

  task automatic m_launch();
    e_n1 = m_a; e_n2 = m_b; e_op = m_op;
    m_pend = m_op ? ((m_a - m_b) & 31) : ((m_a + m_b) & 31);
    m_pneg = (m_op == 1 && m_a < m_b) ? 1 : 0;
    m_left = ALU_LAT + 1;
    e_busy = 1; e_rv = 0; e_neg = 0;
    m_mode = M_RUN;
  endtask

  task automatic m_step();
    int k, t;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_r = m_pend; e_disp = m_pend; e_neg = m_pneg; e_rv = 1; e_busy = 0;
        m_mode = M_SHOW;
      end
      return;
    end
    if (!key_valid || key_code > 13) return;
    k = int'(key_code);
    case (m_mode)
      M_A: begin
        if (k <= 9) begin
          t = m_a * 10 + k;
          if (t <= 15) m_a = t; else e_err = 1;
          e_disp = m_a;
        end else if (k == 10 || k == 11) begin
          m_op = (k == 11); m_b = 0; m_bent = 0; m_mode = M_B;
        end else if (k == 13) begin
          m_a = 0; e_err = 0; e_disp = 0;
        end
      end
      M_B: begin
        if (k <= 9) begin
          t = m_b * 10 + k;
          if (t <= 15) m_b = t; else e_err = 1;
          m_bent = 1; e_disp = m_b;
        end else if (k == 10 || k == 11) begin
          m_op = (k == 11);
        end else if (k == 12) begin
          if (m_bent) m_launch();
        end else begin
          m_b = 0; m_bent = 0; e_err = 0; e_disp = 0;
        end
      end
      M_SHOW: begin
        if (k <= 9) begin
          m_a = k; e_disp = k; e_rv = 0; e_neg = 0; m_mode = M_A;
        end else if (k == 10 || k == 11) begin
          if (e_neg == 0 && m_r <= 15) begin
            m_a = m_r; m_op = (k == 11); m_b = 0; m_bent = 0; e_rv = 0;
            m_mode = M_B;
          end else e_err = 1;
        end else if (k == 12) begin
          if (e_neg == 0 && m_r <= 15) begin
            m_a = m_r; m_launch();
          end else e_err = 1;
        end else begin
          m_reset();
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge clear);
      if (clear) m_reset();
      else m_step();
    end
  end

  // ---------------- comparison ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("disp_value", int'(disp_value), e_disp);
        cmp("result_valid", int'(result_valid), e_rv);
        cmp("negative", int'(negative), e_neg);
        cmp("entry_err", int'(entry_err), e_err);
        cmp("busy", int'(busy), e_busy);
        cmp("alu_num1", int'(alu_num1), e_n1);
        cmp("alu_num2", int'(alu_num2), e_n2);
        cmp("alu_op", int'(alu_op), e_op);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; strobes one key for exactly one cycle.
  task automatic press(input int c);
    key_valid = 1'b1;
    key_code  = 4'(c);
    @(negedge clk);
    key_valid = 1'b0;
    $display("key %0d -> disp=%0d rv=%0b neg=%0b err=%0b busy=%0b",
             c, disp_value, result_valid, negative, entry_err, busy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    idle(2);
    cmp("reset_disp", int'(disp_value), 0);
    cmp("reset_rv", int'(result_valid), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_err", int'(entry_err), 0);
    cmp("reset_num1", int'(alu_num1), 0);
    #2 clear = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 3 + 4 = 7, busy for ALU_LAT+1 cycles
    press(3); press(10); press(4); press(12);
    cmp("add_busy0", int'(busy), 1);
    idle(1);
    cmp("add_busy1", int'(busy), 1);
    cmp("add_rv_early", int'(result_valid), 0);
    idle(1);
    cmp("add_busy_end", int'(busy), 0);
    cmp("add_disp", int'(disp_value), 7);
    cmp("add_rv", int'(result_valid), 1);
    cmp("add_neg", int'(negative), 0);
    press(13);
    cmp("fullclr_disp", int'(disp_value), 0);

    // 9 - 5 = 4, then 3 - 5 = -2
    press(9); press(11); press(5); press(12); idle(2);
    cmp("sub_disp", int'(disp_value), 4);
    press(3); press(11); press(5); press(12); idle(2);
    cmp("neg_disp", int'(disp_value), 30);
    cmp("neg_flag", int'(negative), 1);
    cmp("neg_rv", int'(result_valid), 1);
    press(13);

    // overflow rejection and entry clear
    press(1); press(5);
    cmp("acc15", int'(disp_value), 15);
    press(6);
    cmp("ovf_disp", int'(disp_value), 15);
    cmp("ovf_err", int'(entry_err), 1);
    press(13);
    cmp("c_disp", int'(disp_value), 0);
    cmp("c_err", int'(entry_err), 0);

    // chaining to 16, then chain refused
    press(7); press(10); press(8); press(12); idle(2);
    cmp("r15", int'(disp_value), 15);
    press(10); press(1); press(12); idle(2);
    cmp("chain16", int'(disp_value), 16);
    press(10);
    cmp("refuse_err", int'(entry_err), 1);
    cmp("refuse_rv", int'(result_valid), 1);
    press(13);

    // '=' without B is ignored; operator replaced
    press(2); press(10); press(12);
    cmp("eq_noB_busy", int'(busy), 0);
    press(11); press(1); press(12); idle(2);
    cmp("opswap_disp", int'(disp_value), 1);
    press(13);

    // clear during EXEC abandons the result
    press(4); press(10); press(2); press(12);
    #2 clear = 1'b1;
    idle(1);
    cmp("abort_busy", int'(busy), 0);
    cmp("abort_disp", int'(disp_value), 0);
    #2 clear = 1'b0;
    idle(4);
    cmp("abort_no_rv", int'(result_valid), 0);

    // keys during busy are dropped; repeat '='; ignored codes
    press(5); press(10); press(1); press(12);
    press(9); press(13);
    cmp("busykey_disp", int'(disp_value), 6);
    cmp("busykey_rv", int'(result_valid), 1);
    press(14);
    press(12); idle(2);
    cmp("repeat_disp", int'(disp_value), 7);
    press(4); press(15);
    cmp("ign15_disp", int'(disp_value), 4);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Key-entry sequencer for the calculator's 4-bit add/subtract ALU.
- Accumulates decimal keypad digits into operand A and operand B and latches the operator.
- On '=', drives the ALU operand and op inputs, waits the ALU's registered latency, then captures and holds the result for the display.
- Sits between the keypad decoder and the ALU/display path.

Parameters:
- W, 4, operand width; ALU result width is W+1.
- ALU_LAT, 1, clock cycles from stable ALU inputs to a valid ALU output.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  4  0-9 digit; 10 '+'; 11 '-'; 12 '='; 13 'C' (entry clear); 14-15 ignored.
- alu_num1  out  W  operand A to the ALU.
- alu_num2  out  W  operand B to the ALU.
- alu_op  out  1  0 = add, 1 = subtract.
- alu_result  in  W+1  ALU number_out.
- disp_value  out  W+1  value to display.
- result_valid  out  1  high while a computed result is held.
- negative  out  1  subtract result with A < B.
- entry_err  out  1  sticky flag: a digit was rejected (overflow) or a chain was refused.
- busy  out  1  high in EXEC; keys are dropped.

Behaviour:
- On clear (async, any state): state=ENTER_A; A=B=0; op=0; b_entered=0; all outputs 0; cycle counter=0.
- All outputs are registered. Only the cycle with key_valid=1 acts; keys 14-15 are no-ops everywhere.
- Digit accumulation rule: new = acc*10 + d, computed at ≥ W+4 bits.
  - If new ≤ 2^W-1: acc=new.
  - Otherwise acc is unchanged and entry_err is set.
- entry_err clears only on clear or on the 'C' key.
- States:
  - ENTER_A:
    - digit → accumulate into A; disp_value={0,A}.
    - '+'/'-' → op=0/1; B=0; b_entered=0; go ENTER_B.
    - '=' → ignored.
    - 'C' → A=0; entry_err=0.
  - ENTER_B:
    - digit → accumulate into B; b_entered=1; disp_value={0,B}.
    - '+'/'-' → replace op; no state change.
    - '=' with b_entered=1 → go EXEC. '=' with b_entered=0 → ignored.
    - 'C' → B=0; b_entered=0; entry_err=0; stay.
  - EXEC:
    - busy=1; alu_num1=A, alu_num2=B, alu_op=op held stable for the whole state; counter counts up from 0.
    - When counter==ALU_LAT: capture R=alu_result; disp_value=R; negative=op & (A<B); result_valid=1; go SHOW.
    - Total time from '=' strobe to result_valid is ALU_LAT+2 cycles.
    - All keys are dropped while in EXEC, including 'C'; only clear aborts.
  - SHOW:
    - R is held.
    - digit d → A=d; result_valid=0; negative=0; go ENTER_A.
    - '+'/'-' (chaining):
      - If negative=0 and R ≤ 2^W-1: A=R[W-1:0]; op latched; B=0; b_entered=0; result_valid=0; go ENTER_B.
      - Otherwise: set entry_err and stay in SHOW.
    - '=' → repeat the last operation: A=R[W-1:0] under the same legality check as chaining; B and op are kept; go EXEC.
    - 'C' → full clear equal to reset values; go ENTER_A.
- Subtraction result is the ALU's W+1-bit two's-complement value; this block passes it through unaltered and flags it via negative.
- Clear asserted mid-EXEC: the capture is abandoned; no result_valid pulse follows deassertion.

Test Plan:
- Keys 3,'+',4,'=' → busy high for ALU_LAT+1 cycles; then disp_value=7, result_valid=1, negative=0.
- Keys 9,'-',5,'=' → disp_value=4. Then 3,'-',5,'=' → disp_value=5'b11110, negative=1, result_valid=1.
- Keys 1,5 → A=15. Then 6 → A stays 15, entry_err=1. Then 'C' → A=0, entry_err=0.
- Keys 7,'+',8,'=' (R=15). Then '+',1,'=' → disp_value=16. Then '+' → refused, entry_err=1, state stays SHOW.
- Keys 2,'+','=' → ignored, still ENTER_B. Then '-',1 → op becomes subtract. Then '=' → disp_value=1.
- '=' issued, then clear pulsed on the cycle after → all outputs 0, state ENTER_A, no later result_valid. A key strobed during busy changes nothing.
